// File: rtl/rom_arbiter.sv
// rom_arbiter: N-requester arbiter in front of a shared 1-cycle synchronous ROM.
// Two-stage pipeline: P (ROM read in flight) and R (response register).
// Define ROM_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module rom_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3,
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [ADDRESS_WIDTH-1:0]         rom_address,
    input  logic [DATA_WIDTH-1:0]            rom_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data
);

    localparam int unsigned NR = NUM_REQ;

    logic                     p_valid;
    logic [ID_WIDTH-1:0]      p_id;
    logic [ADDRESS_WIDTH-1:0] p_addr;

    logic                     accept_ok;
    logic                     advance;
    logic                     found;
    logic                     grant;
    logic [ID_WIDTH-1:0]      grant_id;
    logic [ADDRESS_WIDTH-1:0] grant_addr;
    int unsigned              start;
    int unsigned              idx;

`ifndef ROM_ARBITER_FIXED_PRIO_EN
    logic [ID_WIDTH-1:0]      ptr;
`endif

    assign advance   = p_valid && (!rsp_valid || rsp_ready);
    assign accept_ok = !p_valid || !rsp_valid || rsp_ready;
    assign grant     = found && accept_ok && !rst;

    // Priority search over requesters starting at the round-robin pointer (or 0).
    always_comb begin
        found      = 1'b0;
        grant_id   = '0;
        grant_addr = '0;
        idx        = 0;
`ifdef ROM_ARBITER_FIXED_PRIO_EN
        start      = 0;
`else
        start      = 32'(ptr);
`endif
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (start + k) % NR;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant_id   = ID_WIDTH'(idx);
                grant_addr = req_addr[idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    // Grant strobe and ROM address; p_addr is held so rom_data stays stable while stalled.
    always_comb begin
        req_ready   = '0;
        rom_address = '0;
        if (!rst) begin
            if (grant) begin
                req_ready   = NUM_REQ'(1) << grant_id;
                rom_address = grant_addr;
            end else begin
                rom_address = p_addr;
            end
        end
    end

`ifndef ROM_ARBITER_FIXED_PRIO_EN
    // Round-robin pointer: moves just past the last granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    // Stage P: loads on accept, empties when it advances into R.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_id    <= '0;
            p_addr  <= '0;
        end else if (grant) begin
            p_valid <= 1'b1;
            p_id    <= grant_id;
            p_addr  <= grant_addr;
        end else if (advance) begin
            p_valid <= 1'b0;
        end
    end

    // Stage R: captures ROM word from P, clears when consumed with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (advance) begin
            rsp_valid <= 1'b1;
            rsp_id    <= p_id;
            rsp_data  <= rom_data;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ROM word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 3, ROM address width in bits.
REQ-003 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port req_valid, input, NUM_REQ, bit i set = requester i has a read pending.
REQ-007 Port req_addr, input, NUM_REQ*ADDRESS_WIDTH, requester i address in bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-008 Port req_ready, output, NUM_REQ, one-hot (or zero) accept; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 Port rom_address, output, ADDRESS_WIDTH, address to the shared synchronous ROM.
REQ-010 Port rom_data, input, DATA_WIDTH, ROM output; registered, valid one cycle after rom_address is sampled.
REQ-011 Port rsp_valid, output, 1, response holds valid data.
REQ-012 Port rsp_ready, input, 1, response consumer accepts.
REQ-013 Port rsp_id, output, $clog2(NUM_REQ) (min 1), index of the requester owning the response.
REQ-014 Port rsp_data, output, DATA_WIDTH, ROM word read for that requester.

Function
REQ-015 Two-stage pipeline: P (ROM read in flight: p_valid, p_id, p_addr) and R (response register: rsp_valid, rsp_id, rsp_data).
REQ-016 P advances into R at a clock edge iff p_valid and (!rsp_valid or rsp_ready); R captures rom_data and p_id.
REQ-017 R clears at an edge iff rsp_valid and rsp_ready and P does not advance.
REQ-018 accept_ok = !p_valid or !rsp_valid or rsp_ready; no req_ready bit SHALL be high when accept_ok is low.
REQ-019 When accept_ok and any req_valid bit is set, exactly one req_ready bit SHALL be high, selected by the arbitration rule; the accepted id/address load into P.
REQ-020 rom_address SHALL equal the granted requester's address in an accept cycle, else p_addr (held so rom_data stays stable while P is stalled).
REQ-021 Latency: accept in cycle N -> rsp_valid high in cycle N+2 when R is free; sustained throughput one read per cycle with rsp_ready held high.
REQ-022 Round-robin: priority search starts at index ptr; after each grant ptr = (granted index + 1) mod NUM_REQ; ptr unchanged in cycles with no grant.
REQ-023 Responses SHALL be delivered in acceptance order; none dropped or duplicated.
REQ-024 rsp_id and rsp_data SHALL remain stable while rsp_valid high and rsp_ready low.
REQ-025 A requester dropping req_valid without a grant SHALL be ignored; requests are not latched.

Reset
REQ-026 While rst high at an edge: p_valid, rsp_valid, ptr, p_id, p_addr, rsp_id, rsp_data cleared to 0.
REQ-027 req_ready SHALL be 0 and rom_address SHALL be 0 in any cycle where rst is high.
REQ-028 Reset mid-operation SHALL discard in-flight P and R contents; first grant after reset favours requester 0.

Configuration
REQ-029 Macro ROM_ARBITER_FIXED_PRIO_EN: if defined, lowest-index valid requester always wins and ptr is not implemented; if undefined, REQ-022 round-robin applies.

Verification (bench ROM: 1-cycle registered, mem[a] = 8'hA0 + a)
REQ-030 Single read: req_valid=4'b0001, addr0=3, rsp_ready=1 -> req_ready=4'b0001 in cycle N, rsp_valid in N+2 with rsp_id=0, rsp_data=8'hA3.
REQ-031 Round-robin fairness: all four valid continuously, addr i=i -> grants 0,1,2,3,0,... one per cycle, responses A0,A1,A2,A3 in order, ids 0..3.
REQ-032 Backpressure: two back-to-back accepts, rsp_ready=0 for 5 cycles -> rsp_valid held with first word, req_ready=0 while P and R full, rom_address held; after release both responses emerge in order, none lost.
REQ-033 Reset mid-operation: rst pulsed one cycle with P and R full -> rsp_valid=0 next cycle, no stale response afterwards, next grant to requester 0.
REQ-034 Fixed priority (ROM_ARBITER_FIXED_PRIO_EN defined): requesters 1 and 3 continuously valid -> requester 1 granted every cycle, requester 3 never.
REQ-035 Assertions throughout: req_ready one-hot-or-zero, req_ready subset of req_valid, rsp_data matches model for rsp_id's accepted address.
